// File: rtl/axi4_reg_master.sv
// Single-outstanding AXI4 register master: one command in, one AXI read or write, one response out.
// Optional wait-state watchdog enabled by defining AXI4_REG_MASTER_TIMEOUT_EN.
module axi4_reg_master #(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int TIMEOUT_CYCLES_P = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [AXI_ADDR_WIDTH_P-1:0]   awaddr,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [AXI_DATA_WIDTH_P-1:0]   wdata,
  output logic [AXI_DATA_WIDTH_P/8-1:0] wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [AXI_ADDR_WIDTH_P-1:0]   araddr,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [AXI_DATA_WIDTH_P-1:0]   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W offered, each dropped after its own handshake
  // WR_RESP | bready high, waiting for B
  // RD_REQ  | AR offered, waiting for arready
  // RD_DATA | rready high, waiting for R
  // RSP     | rsp_valid high, holding the response until rsp_ready
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  localparam int STRB_W = AXI_DATA_WIDTH_P / 8;

  state_t                  state;
  logic [AXI_ADDR_WIDTH_P-1:0] addr_q;
  logic [AXI_DATA_WIDTH_P-1:0] wdata_q;
  logic [STRB_W-1:0]           wstrb_q;
  logic                        aw_done;
  logic                        w_done;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

`ifdef AXI4_REG_MASTER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES_P > 1) ? $clog2(TIMEOUT_CYCLES_P) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES_P - 1);

  logic [TMR_W-1:0] tmr;
  logic             timeout_q;
  logic             wait_st;
  logic             progress;
  logic             expire;

  always_comb begin
    wait_st  = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    progress = 1'b0;
    case (state)
      WR_REQ:  progress = aw_done && w_done;
      WR_RESP: progress = bvalid;
      RD_REQ:  progress = arready;
      RD_DATA: progress = rvalid;
      default: progress = 1'b0;
    endcase
    expire = wait_st && (tmr == '0) && !progress;
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
      tmr       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
      // Down-counter; every transition into a wait state reloads it below.
      if (wait_st) tmr <= tmr - TMR_W'(1);
`endif
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
            tmr       <= TMR_LOAD;
            timeout_q <= 1'b0;
`endif
            if (cmd_write) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD_REQ;
              arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state  <= WR_RESP;
            bready <= 1'b1;
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
            tmr    <= TMR_LOAD;
`endif
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
            tmr     <= TMR_LOAD;
`endif
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_resp  <= rresp;
            rsp_rdata <= rdata;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
      if (expire) begin
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        rsp_resp  <= 2'b11;
        rsp_rdata <= '0;
        timeout_q <= 1'b1;
        rsp_valid <= 1'b1;
        state     <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_reg_master.sv
// Bench for axi4_reg_master: behavioural AXI slave with per-channel delays plus a byte-level memory model.
// Cycle numbering for latency: the cycle in which the command handshake is presented is cycle 1.
module tb_axi4_reg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  axi4_reg_master #(
    .AXI_ADDR_WIDTH_P(16), .AXI_DATA_WIDTH_P(32), .TIMEOUT_CYCLES_P(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // Slave knobs and handshake counters
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] slv_mem [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];

  bit aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p, got_aw, got_w, b_armed, r_armed;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic [15:0] aw_addr_c, ar_addr_c, r_addr;
  logic [31:0] w_data_c, slv_old;
  logic [3:0]  w_strb_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Slave drives on the falling edge; handshakes seen as pending here happen on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
      got_aw = 0; got_w = 0; b_armed = 0; r_armed = 0;
      aw_wait = aw_delay; w_wait = w_delay; ar_wait = ar_delay;
    end else begin
      if (aw_hs_p) begin aw_cnt++; got_aw = 1; awready = 0; aw_wait = aw_delay; end
      else if (!awvalid) aw_wait = aw_delay;
      else if (!awready) begin if (aw_wait == 0) awready = 1; else aw_wait--; end

      if (w_hs_p) begin w_cnt++; got_w = 1; wready = 0; w_wait = w_delay; end
      else if (!wvalid) w_wait = w_delay;
      else if (!wready) begin if (w_wait == 0) wready = 1; else w_wait--; end

      if (ar_hs_p) begin
        ar_cnt++; arready = 0; ar_wait = ar_delay;
        r_armed = 1; r_wait = r_delay; r_addr = ar_addr_c;
      end
      else if (!arvalid) ar_wait = ar_delay;
      else if (!arready) begin if (ar_wait == 0) arready = 1; else ar_wait--; end

      if (got_aw && got_w) begin
        slv_old = slv_mem.exists(aw_addr_c) ? slv_mem[aw_addr_c] : 32'h0;
        slv_mem[aw_addr_c] = merge_bytes(slv_old, w_data_c, w_strb_c);
        got_aw = 0; got_w = 0; b_armed = 1; b_wait = b_delay;
      end
      if (b_hs_p) begin b_cnt++; bvalid = 0; end
      if (b_armed) begin
        if (b_wait == 0) begin bvalid = 1; bresp = bresp_k; b_armed = 0; end
        else b_wait--;
      end
      if (r_hs_p) begin r_cnt++; rvalid = 0; end
      if (r_armed) begin
        if (r_wait == 0) begin
          rvalid = 1; rresp = rresp_k; r_armed = 0;
          rdata = slv_mem.exists(r_addr) ? slv_mem[r_addr] : 32'h0;
        end else r_wait--;
      end

      aw_hs_p = awvalid && awready; if (aw_hs_p) aw_addr_c = awaddr;
      w_hs_p  = wvalid && wready;   if (w_hs_p) begin w_data_c = wdata; w_strb_c = wstrb; end
      ar_hs_p = arvalid && arready; if (ar_hs_p) ar_addr_c = araddr;
      b_hs_p  = bvalid && bready;
      r_hs_p  = rvalid && rready;
    end
  end

  // Returns on the falling edge that follows the accepting rising edge (cycle 2).
  task automatic start_cmd(input bit w, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    ok = cmd_ready;
    if (ok) @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 2;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    ok = rsp_valid;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic do_cmd(input bit w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic [1:0] rs,
                        output logic to, output int lat, output bit ok);
    bit ok1, ok2;
    start_cmd(w, a, d, s, ok1);
    lat = 0; ok2 = 0;
    if (ok1) wait_rsp(lat, ok2);
    ok = ok1 && ok2;
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    repeat (hold) @(negedge clk);
    if (ok) finish_rsp();
  endtask

  task automatic test_reset();
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready,
         rsp_rdata, rsp_resp, awaddr, araddr, wdata, wstrb} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctl=%b rdata=%h resp=%b awaddr=%h expected all zero",
               {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready},
               rsp_rdata, rsp_resp, awaddr);
    end
    rst = 0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL cmd_ready_before_edge: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL cmd_ready_first_edge: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; logic [1:0] rs; logic to; int lat; bit ok;
    slv_mem[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
    rresp_k = 2'b00;
    do_cmd(0, 16'h0010, 32'h0, 4'h0, 0, rd, rs, to, lat, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL read_basic_done: got no response expected response"); end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL read_latency: got %0d expected 4", lat); end
    vectors++;
    if ({rd, rs, to} !== {32'hDEADBEEF, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL read_basic_data: got rdata=%h resp=%b to=%b expected DEADBEEF/00/0", rd, rs, to);
    end
  endtask

  task automatic test_write_zero_wait();
    logic [31:0] rd; logic [1:0] rs; logic to; int lat; bit ok;
    bresp_k = 2'b00;
    ref_mem[16'h0008] = merge_bytes(ref_read(16'h0008), 32'hA5A55A5A, 4'hF);
    do_cmd(1, 16'h0008, 32'hA5A55A5A, 4'hF, 0, rd, rs, to, lat, ok);
    vectors++;
    if (!ok || lat !== 4) begin
      miscompares++; $display("FAIL write_latency: got ok=%b lat=%0d expected ok=1 lat=4", ok, lat);
    end
    vectors++;
    if ({rd, rs} !== {32'h0, 2'b00}) begin
      miscompares++; $display("FAIL write_zero_rsp: got rdata=%h resp=%b expected 0/00", rd, rs);
    end
  endtask

  task automatic test_write_aw_late();
    int aw0, w0, b0, lat; bit ok;
    logic [31:0] rd; logic [1:0] rs;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    aw_delay = 3; w_delay = 0; bresp_k = 2'b00;
    ref_mem[16'h0004] = merge_bytes(ref_read(16'h0004), 32'h12345678, 4'hF);
    start_cmd(1, 16'h0004, 32'h12345678, 4'hF, ok);
    vectors++;
    if ({ok, awvalid, wvalid} !== 3'b111) begin
      miscompares++;
      $display("FAIL aw_w_together: got ok=%b awvalid=%b wvalid=%b expected 1/1/1", ok, awvalid, wvalid);
    end
    @(negedge clk);
    vectors++;
    if ({awvalid, wvalid} !== 2'b10) begin
      miscompares++; $display("FAIL w_drop_alone: got aw/w=%b expected 10", {awvalid, wvalid});
    end
    wait_rsp(lat, ok);
    rd = rsp_rdata; rs = rsp_resp;
    vectors++;
    if (!ok || {rd, rs} !== {32'h0, 2'b00}) begin
      miscompares++; $display("FAIL aw_late_rsp: got ok=%b rdata=%h resp=%b expected 1/0/00", ok, rd, rs);
    end
    if (ok) finish_rsp();
    aw_delay = 0;
    vectors++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL single_handshakes: got aw=%0d w=%0d b=%0d expected 1/1/1",
               aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
    end
    vectors++;
    if (slv_mem[16'h0004] !== 32'h12345678) begin
      miscompares++; $display("FAIL slave_write_data: got %h expected 12345678", slv_mem[16'h0004]);
    end
  endtask

  task automatic test_read_slverr();
    logic [31:0] rd; logic [1:0] rs; logic to; int lat, ar0; bit ok;
    ar0 = ar_cnt; rresp_k = 2'b10;
    do_cmd(0, 16'h0010, 32'h0, 4'h0, 0, rd, rs, to, lat, ok);
    rresp_k = 2'b00;
    repeat (3) @(negedge clk);
    vectors++;
    if (!ok || {rd, rs} !== {ref_read(16'h0010), 2'b10}) begin
      miscompares++;
      $display("FAIL slverr_rsp: got ok=%b rdata=%h resp=%b expected 1/%h/10", ok, rd, rs, ref_read(16'h0010));
    end
    vectors++;
    if (ar_cnt - ar0 !== 1 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL slverr_no_retry: got ar=%0d cmd_ready=%b expected 1/1", ar_cnt - ar0, cmd_ready);
    end
  endtask

  task automatic test_rsp_backpressure();
    int lat; bit ok;
    start_cmd(0, 16'h0008, 32'h0, 4'h0, ok);
    if (ok) wait_rsp(lat, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_response: got no response expected response"); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {1'b1, 1'b0, ref_read(16'h0008), 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid=%b cmd_ready=%b rdata=%h resp=%b expected 1/0/%h/00",
                 i, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, ref_read(16'h0008));
      end
      @(negedge clk);
    end
    if (ok) finish_rsp();
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bvalid = 1; rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, cmd_ready, bready, rready} !== 4'b0100) begin
        miscompares++;
        $display("FAIL spurious_%0d: got %b expected 0100", i, {rsp_valid, cmd_ready, bready, rready});
      end
    end
    bvalid = 0; rvalid = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; logic to; int lat; bit ok;
    aw_delay = 20; w_delay = 20;
    start_cmd(1, 16'h0004, 32'hCAFEF00D, 4'hF, ok);
    vectors++;
    if (!ok || awvalid !== 1'b1) begin
      miscompares++; $display("FAIL mid_awvalid: got ok=%b awvalid=%b expected 1/1", ok, awvalid);
    end
    rst = 1;
    #1;
    vectors++;
    if ({awvalid, wvalid, bready, cmd_ready, rsp_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset_drop: got %b expected 00000", {awvalid, wvalid, bready, cmd_ready, rsp_valid});
    end
    aw_delay = 0; w_delay = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    do_cmd(0, 16'h0004, 32'h0, 4'h0, 0, rd, rs, to, lat, ok);
    vectors++;
    if (!ok || {rd, rs} !== {ref_read(16'h0004), 2'b00}) begin
      miscompares++;
      $display("FAIL after_reset_read: got ok=%b rdata=%h resp=%b expected 1/%h/00", ok, rd, rs, ref_read(16'h0004));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd; logic [1:0] rs, exp_rs; logic to; int lat, hold; bit ok, w;
    logic [15:0] a; logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 15) * 4);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      bresp_k = 2'($urandom_range(0, 3)); rresp_k = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 3);
      if (w) begin
        exp_rd = 32'h0; exp_rs = bresp_k;
        ref_mem[a] = merge_bytes(ref_read(a), d, s);
      end else begin
        exp_rd = ref_read(a); exp_rs = rresp_k;
      end
      do_cmd(w, a, d, s, hold, rd, rs, to, lat, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rand_%0d_done: got no response expected response", i); end
      vectors++;
      if ({rd, rs, to} !== {exp_rd, exp_rs, 1'b0}) begin
        miscompares++;
        $display("FAIL rand_%0d w=%b a=%h: got rdata=%h resp=%b to=%b expected %h/%b/0",
                 i, w, a, rd, rs, to, exp_rd, exp_rs);
      end
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0; bresp_k = 0; rresp_k = 0;
  endtask

`ifdef AXI4_REG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok;
    ar_delay = 1000;
    start_cmd(0, 16'h0010, 32'h0, 4'h0, ok);
    n = 0;
    while (ok && arvalid && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL timeout_cycles: got %0d expected 8", n); end
    vectors++;
    if ({arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {4'b0011, 2'b11, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_rsp: got arv=%b rr=%b valid=%b to=%b resp=%b rdata=%h expected 0/0/1/1/11/0",
               arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
    end
    if (rsp_valid) finish_rsp();
    ar_delay = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_zero_wait();
    test_write_aw_late();
    test_read_slverr();
    test_rsp_backpressure();
    test_spurious();
    test_reset_mid();
`ifdef AXI4_REG_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 expected finish");
    $fatal(1);
  end

endmodule
